// File: rtl/xadc_avg_core.sv
// rtl/xadc_avg_core.sv - XADC DRP reader with per-channel boxcar averaging
module xadc_avg_core #(
    parameter int                  NUM_CH   = 4,
    parameter logic [NUM_CH*5-1:0] CH_ADDR  = {5'h1B, 5'h12, 5'h1A, 5'h13},
    parameter int                  AVG_LOG2 = 2,
    parameter int                  TIMEOUT  = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 eoc,
    input  logic [4:0]           channel,
    input  logic                 drdy,
    input  logic [15:0]          do_in,
    input  logic                 clr_err,
    output logic                 den,
    output logic [6:0]           daddr,
    output logic                 dwe,
    output logic [NUM_CH*12-1:0] ch_data,
    output logic [NUM_CH-1:0]    ch_valid,
    output logic [NUM_CH-1:0]    ch_update,
    output logic [7:0]           overrun_cnt,
    output logic                 timeout_err
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT_RDY} state_t;

    state_t            state;
    state_t            next_state;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [IDX_W-1:0]  cur_idx;
    logic [TMR_W-1:0]  timer;
    logic              timer_done;
    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [ACC_W-1:0]  sum;
    logic [11:0]       avg;
    logic              sample_en;
    logic              unused_bits;

    assign dwe         = 1'b0;
    assign unused_bits = ^do_in[3:0];
    assign timer_done  = (timer == TMR_W'(TIMEOUT - 1));
    assign sample_en   = (state == WAIT_RDY) && drdy;
    assign sum         = acc[cur_idx] + ACC_W'(do_in[15:4]);
    assign avg         = 12'(sum >> AVG_LOG2);

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (channel == CH_ADDR[5*i +: 5]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        den        = 1'b0;
        case (state)
            IDLE:     if (eoc && hit) next_state = READ;
            READ: begin
                den        = 1'b1;
                next_state = WAIT_RDY;
            end
            WAIT_RDY: if (drdy || timer_done) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            daddr       <= '0;
            cur_idx     <= '0;
            timer       <= '0;
            ch_data     <= '0;
            ch_valid    <= '0;
            ch_update   <= '0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            ch_update <= '0;

            // A match means channel equals the table entry, so it is the address.
            if (state == IDLE && eoc && hit) begin
                cur_idx <= hit_idx;
                daddr   <= {2'b00, channel};
            end

            if (state == WAIT_RDY) timer <= timer + 1'b1;
            else                   timer <= '0;

            if (sample_en) begin
                if (cnt[cur_idx] == CNT_LAST) begin
                    ch_data[12*cur_idx +: 12] <= avg;
                    ch_update[cur_idx]        <= 1'b1;
                    ch_valid[cur_idx]         <= 1'b1;
                    acc[cur_idx]              <= '0;
                    cnt[cur_idx]              <= '0;
                end else begin
                    acc[cur_idx] <= sum;
                    cnt[cur_idx] <= cnt[cur_idx] + 1'b1;
                end
            end

            if (clr_err)
                overrun_cnt <= '0;
            else if (eoc && hit && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            if (clr_err)
                timeout_err <= 1'b0;
            else if (state == WAIT_RDY && !drdy && timer_done)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: doc/xadc_avg_core.md
# xadc_avg_core

Parametrised XADC DRP reader with per-channel boxcar averaging, for the joystick and analogue-input path. Sits between the XADC hard-macro wrapper (continuous-sequence mode, EOC-driven) and the sprite/controller logic. Issues DRP reads for a configurable set of auxiliary channels, averages 2^AVG_LOG2 samples per channel, and publishes 12-bit results with update strobes, a dropped-conversion count and a DRP timeout flag.

## Interface
Parameters:
- NUM_CH, 4: number of monitored channels, 1..8.
- CH_ADDR, {5'h1B,5'h12,5'h1A,5'h13}: packed NUM_CH×5 DRP addresses; entry i is bits [5i+4:5i].
- AVG_LOG2, 2: log2 of samples averaged per output, 0..4.
- TIMEOUT, 64: maximum cycles from den to drdy, ≥4.

Ports:
- clk  in  1  system clock, also the XADC dclk.
- reset  in  1  reset. One clock; reset is asynchronous and active-low.
- eoc  in  1  XADC end-of-conversion pulse.
- channel  in  5  XADC channel_out, valid with eoc.
- drdy  in  1  XADC DRP data ready.
- do_in  in  16  XADC DRP read data, left-aligned 12-bit result.
- den  out  1  DRP enable, one-cycle pulse.
- daddr  out  7  DRP address, {2'b00, addr}.
- dwe  out  1  tied 0.
- ch_data  out  NUM_CH×12  averaged result; channel i at [12i+11:12i].
- ch_valid  out  NUM_CH  sticky; bit i set after the first average of channel i.
- ch_update  out  NUM_CH  one-cycle pulse when ch_data[i] changes register value (written).
- overrun_cnt  out  8  saturating count of dropped EOCs.
- timeout_err  out  1  sticky DRP timeout flag.
- clr_err  in  1  synchronous clear of overrun_cnt and timeout_err.

## Operation
- FSM: IDLE, READ, WAIT_RDY. Reset state IDLE.
- IDLE: on eoc, compare channel against all CH_ADDR entries. Match at index i → latch i, go READ. No match → stay IDLE, nothing counted. Multiple matching entries: lowest index wins.
- READ: den=1, daddr={2'b00,CH_ADDR[i]} for exactly one cycle; go WAIT_RDY, timer cleared.
- WAIT_RDY: drdy → sample = do_in[15:4], accumulate, go IDLE. Timer reaches TIMEOUT with no drdy → set timeout_err, discard, go IDLE, accumulator untouched.
- eoc in READ or WAIT_RDY with matching channel: conversion dropped, overrun_cnt += 1 (saturate at 255). Same cycle as drdy in WAIT_RDY: still dropped.
- Averaging, per channel: accumulator (12+AVG_LOG2 bits, no overflow possible), sample counter (AVG_LOG2 bits). On sample: if counter = 2^AVG_LOG2−1, ch_data[i] ← (acc+sample)>>AVG_LOG2 (truncating), acc ← 0, counter ← 0, ch_update[i] pulse, ch_valid[i] ← 1; else acc += sample, counter += 1.
- AVG_LOG2=0: every sample written directly.
- clr_err has priority over same-cycle increment/set: result is 0.
- daddr holds last address outside READ; dwe constantly 0.

## Timing
- Reset values: den 0, daddr 0, ch_data 0, ch_valid 0, ch_update 0, overrun_cnt 0, timeout_err 0, all accumulators/counters 0, FSM IDLE.
- eoc at cycle t (IDLE) → den at t+1.
- drdy at cycle d → ch_data/ch_update/ch_valid at d+1 (registered); FSM back in IDLE at d+1, accepts eoc at d+1.
- den to timeout: timeout_err set at den cycle + TIMEOUT + 1 if no drdy.
- Reset asserted mid-transaction: immediate return to reset values; a drdy arriving after release in IDLE is ignored.
- drdy in IDLE or READ: ignored.

## Test plan
- AVG_LOG2=2, channel 0x13 samples do_in 0x1000,0x2000,0x3000,0x4000 → single ch_update[0] after 4th, ch_data[0]=0x280, ch_valid[0]=1; no update after samples 1–3.
- AVG_LOG2=0, eoc with channel 0x1A, drdy 3 cycles after den with do_in 0xFFF0 → den one cycle at t+1, daddr=0x1A, ch_data[1]=0xFFF, ch_update[1] pulse.
- eoc with channel 0x05 (unmapped) → no den, overrun_cnt stays 0, outputs unchanged.
- Second matching eoc during WAIT_RDY ×300 → overrun_cnt saturates at 255; clr_err → 0 next cycle.
- TIMEOUT=8, no drdy → timeout_err=1 at den+9, FSM IDLE, ch_data unchanged; next eoc/drdy completes normally.
- reset low during WAIT_RDY after 2 of 4 samples → all outputs 0; after release 4 fresh samples of 0x0100 give ch_data=0x010 (old partial sum discarded).
